// File: rtl/sort_stream_serializer_if.sv
// Handshake bundle for sort_stream_serializer: parallel sorted-vector input
// side and narrow element-stream output side.
interface sort_stream_serializer_if #(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 2
);
  localparam int SIZE = 1 << DEPTH;

  logic                                in_valid;
  logic                                in_ready;
  logic [SIZE-1:0][VALUE_BITS-1:0]     in;
  logic                                out_valid;
  logic                                out_ready;
  logic [VALUE_BITS-1:0]               out;
  logic                                out_last;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_last
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_last
  );
endinterface

// File: rtl/sort_stream_serializer.sv
// Replays a parallel sorted vector as an element stream through a two-slot
// ping-pong buffer. Define SORT_STREAM_SERIALIZER_REVERSE_EN to emit index SIZE-1 first.
module sort_stream_serializer #(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 2,
  localparam int SIZE      = 1 << DEPTH
) (
  input logic                    clk,
  input logic                    rst,
  sort_stream_serializer_if.slave bus
);

  localparam logic [DEPTH-1:0] IDX_ZERO = {DEPTH{1'b0}};
  localparam logic [DEPTH-1:0] IDX_ALL1 = {DEPTH{1'b1}};
  localparam logic [DEPTH-1:0] IDX_ONE  = DEPTH'(1);

`ifdef SORT_STREAM_SERIALIZER_REVERSE_EN
  localparam logic [DEPTH-1:0] IDX_FIRST = IDX_ALL1;
  localparam logic [DEPTH-1:0] IDX_LAST  = IDX_ZERO;
`else
  localparam logic [DEPTH-1:0] IDX_FIRST = IDX_ZERO;
  localparam logic [DEPTH-1:0] IDX_LAST  = IDX_ALL1;
`endif

  // Occupancy of the ping-pong buffer doubles as the FSM state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            r_wr_slot;
  logic                            r_rd_slot;
  logic [DEPTH-1:0]                r_idx;
  logic [DEPTH-1:0]                w_idx_nxt;
  logic [SIZE-1:0][VALUE_BITS-1:0] r_slot [2];

  logic                            w_in_ready;
  logic                            w_out_valid;
  logic                            w_accept;
  logic                            w_xfer;
  logic                            w_is_last;
  logic                            w_release;
  logic [VALUE_BITS-1:0]           w_out;

  // Handshake terms; ready/valid depend on registered state only.
  always_comb begin
    w_in_ready  = (r_state != ST_FULL);
    w_out_valid = (r_state != ST_EMPTY);
    w_accept    = bus.in_valid && w_in_ready;
    w_xfer      = w_out_valid && bus.out_ready;
    w_is_last   = (r_idx == IDX_LAST);
    w_release   = w_xfer && w_is_last;
  end

  // Occupancy next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_release) begin
          w_state_nxt = ST_FULL;
        end else if (w_release && !w_accept) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_FULL: begin
        if (w_release) begin
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Element index walks through the read slot and rewinds on the last transfer.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_xfer) begin
      if (w_is_last) begin
        w_idx_nxt = IDX_FIRST;
      end else begin
`ifdef SORT_STREAM_SERIALIZER_REVERSE_EN
        w_idx_nxt = r_idx - IDX_ONE;
`else
        w_idx_nxt = r_idx + IDX_ONE;
`endif
      end
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Output element mux, forced to zero while nothing is buffered.
  always_comb begin
    w_out = {VALUE_BITS{1'b0}};
    if (w_out_valid) begin
      w_out = r_slot[r_rd_slot][r_idx];
    end else begin
      w_out = {VALUE_BITS{1'b0}};
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_wr_slot <= 1'b0;
      r_rd_slot <= 1'b0;
      r_idx     <= IDX_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_wr_slot <= ~r_wr_slot;
      end
      if (w_release) begin
        r_rd_slot <= ~r_rd_slot;
      end
    end
  end

  // Slot storage; captures the input vector only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
    end else if (w_accept) begin
      r_slot[r_wr_slot] <= bus.in;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = w_out;
  assign bus.out_last  = w_out_valid && w_is_last;

endmodule

// File: tb/tb_sort_stream_serializer.sv
// Self-checking bench for sort_stream_serializer: table-driven single vector,
// directed multi-cycle sequences and a randomized run against a queue model.
module tb_sort_stream_serializer;
  localparam int VB    = 8;
  localparam int DEPTH = 2;
  localparam int SIZE  = 4;

  typedef logic [SIZE-1:0][VB-1:0] vec_t;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    logic [VB-1:0] e_out;
    logic          e_last;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sort_stream_serializer_if #(.VALUE_BITS(VB), .DEPTH(DEPTH)) bus ();

  sort_stream_serializer #(.VALUE_BITS(VB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  vec_t          m_q[$];
  int            m_pos;
  logic [VB-1:0] got_q[$];

  // Position k of the stream comes from this element index.
  function automatic int ord(input int k);
`ifdef SORT_STREAM_SERIALIZER_REVERSE_EN
    return SIZE - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = VB'(a);
    v[1] = VB'(b);
    v[2] = VB'(c);
    v[3] = VB'(d);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in       = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_pos = 0;
    got_q.delete();
  endtask

  // One cycle: drive inputs, compare against the queue model, clock, advance model.
  task automatic step(input logic iv, input vec_t d, input logic ordy, output logic acc);
    logic          m_rdy;
    logic          m_ov;
    logic          m_last;
    logic          xfer;
    logic [VB-1:0] m_out;
    vec_t          head;
    bus.in_valid  = iv;
    bus.in        = d;
    bus.out_ready = ordy;
    m_rdy  = (m_q.size() < 2);
    m_ov   = (m_q.size() > 0);
    m_out  = '0;
    m_last = 1'b0;
    if (m_ov) begin
      head   = m_q[0];
      m_out  = head[ord(m_pos)];
      m_last = (m_pos == SIZE - 1);
    end
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out", 32'(bus.out), 32'(m_out));
    chk("out_last", 32'(bus.out_last), 32'(m_last));
    acc  = iv && m_rdy;
    xfer = ordy && m_ov;
    if (xfer) got_q.push_back(bus.out);
    @(posedge clk);
    if (xfer) begin
      m_pos++;
      if (m_pos == SIZE) begin
        void'(m_q.pop_front());
        m_pos = 0;
      end
    end
    if (acc) m_q.push_back(d);
    #1;
  endtask

  row_t tbl[6];
  vec_t va, vb, vc, vtab;
  vec_t pend;
  logic pv;
  logic acc;
  int   acc_at;
  int   cnt;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in       = '0;
    @(posedge clk);
    do_reset();

    // Reset state.
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);

    // Table: single vector {3,7,9,12} with out_ready held high.
    vtab = mk(3, 7, 9, 12);
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int k = 0; k < SIZE; k++) begin
      tbl[k+1] = '{1'b0, 1'b1, 1'b1, 1'b1, vtab[ord(k)], (k == SIZE - 1)};
    end
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int r = 0; r < 6; r++) begin
      bus.in_valid  = tbl[r].iv;
      bus.in        = vtab;
      bus.out_ready = tbl[r].ordy;
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[r].e_rdy));
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[r].e_ov));
      chk("tbl_out", 32'(bus.out), 32'(tbl[r].e_out));
      chk("tbl_out_last", 32'(bus.out_last), 32'(tbl[r].e_last));
      step(tbl[r].iv, vtab, tbl[r].ordy, acc);
    end

    // Back-to-back fill, stall, then drain with C held until a slot frees.
    do_reset();
    va = mk(1, 2, 3, 4);
    vb = mk(5, 6, 7, 8);
    vc = mk(9, 10, 11, 12);
    step(1'b1, va, 1'b0, acc);
    step(1'b1, vb, 1'b0, acc);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, vc, 1'b0, acc);
    chk("full_no_accept", 32'(acc), 32'd0);
    pv     = 1'b1;
    acc_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(pv, vc, 1'b1, acc);
      if (acc) begin
        acc_at = i;
        pv     = 1'b0;
      end
    end
    chk("c_accept_cycle", 32'(acc_at), 32'd4);
    chk("b2b_count", 32'(got_q.size()), 32'd12);
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (got_q.size() > v * SIZE + k)
          chk("b2b_stream", 32'(got_q[v*SIZE+k]), 32'(4 * v + ord(k) + 1));
      end
    end
    step(1'b0, vc, 1'b1, acc);
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: out_ready pattern 1,0,0,1 repeating.
    do_reset();
    va = mk(10, 20, 30, 40);
    step(1'b1, va, 1'b0, acc);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, va, ((i % 4) == 0) || ((i % 4) == 3), acc);
    end
    chk("bp_count", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < SIZE; k++) begin
      if (got_q.size() > k) chk("bp_stream", 32'(got_q[k]), 32'(va[ord(k)]));
    end

    // Reset after two of four elements transferred.
    do_reset();
    va = mk(100, 101, 102, 103);
    step(1'b1, va, 1'b1, acc);
    step(1'b0, va, 1'b1, acc);
    step(1'b0, va, 1'b1, acc);
    chk("mid_two_done", 32'(got_q.size()), 32'd2);
    do_reset();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out", 32'(bus.out), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    vb = mk(50, 60, 70, 80);
    step(1'b1, vb, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b0, vb, 1'b1, acc);
    chk("mid_new_count", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < SIZE; k++) begin
      if (got_q.size() > k) chk("mid_new_stream", 32'(got_q[k]), 32'(vb[ord(k)]));
    end

    // Randomized traffic against the queue model; upstream holds data until accepted.
    do_reset();
    pv   = 1'b0;
    pend = '0;
    cnt  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv && ($urandom_range(0, 3) != 0)) begin
        pend = vec_t'($urandom);
        pv   = 1'b1;
      end
      step(pv, pend, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        pv = 1'b0;
        cnt++;
      end
    end
    chk("rand_progress", 32'(cnt > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sort_stream_serializer.md
Name: sort_stream_serializer

Overview:
- Output-side counterpart of the bitonic sorter/merger pipeline.
- Accepts a full sorted vector of SIZE elements in one parallel transfer and replays it as a stream, one element per cycle, with valid/ready backpressure.
- Sits between the last merger stage and any narrow downstream consumer.
- A two-slot ping-pong buffer lets the next vector land while the current one is still draining.

Parameters:
- VALUE_BITS, 8, width of one element.
- DEPTH, 2, log2 of vector length; must be >= 1.
- SIZE, 1 << DEPTH, derived element count; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  parallel vector present on in.
- in_ready  output  1  a buffer slot is free.
- in  input  [SIZE-1:0][VALUE_BITS-1:0]  sorted vector; element 0 is emitted first.
- out_valid  output  1  out holds a valid element.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  VALUE_BITS  current element.
- out_last  output  1  high with the final element of a vector.

Behaviour:
- Storage: two slots of SIZE x VALUE_BITS, plus:
  - wr_slot, 1 bit;
  - rd_slot, 1 bit;
  - count, 0..2;
  - idx, DEPTH bits, element index within rd_slot.
- Reset (rst high at an edge):
  - count = 0, wr_slot = rd_slot = 0, idx = 0, all slot contents = 0.
  - Outputs after reset: out_valid = 0, out_last = 0, out = 0, in_ready = 1.
  - Reset mid-vector discards all buffered data; no partial vector resumes.
- in_ready = (count < 2). It is a function of registered state only, with no same-cycle bypass from an output release.
- Input accept when in_valid && in_ready:
  - in is written into slot wr_slot;
  - wr_slot toggles.
- in is sampled only on accept; in_valid with in_ready low is ignored, and upstream must hold the data.
- out_valid = (count > 0).
- out = slot[rd_slot][idx] when out_valid is high; otherwise 0.
- out_last = out_valid && (idx == SIZE-1).
- Output transfer when out_valid && out_ready:
  - if idx != SIZE-1: idx increments;
  - if idx == SIZE-1: idx wraps to 0, rd_slot toggles and the slot is released.
- Count update:
  - accept and no release: count + 1;
  - release and no accept: count - 1;
  - both in the same cycle: count unchanged;
  - neither: count unchanged.
- Latency:
  - a vector accepted at edge N presents element 0 in the cycle after N, provided no older vector is pending;
  - a queued vector presents element 0 in the cycle after the previous vector's last transfer, with no bubble;
  - sustained throughput is SIZE elements per SIZE cycles.
- out_ready low: out, out_valid, out_last and idx hold stable (AXI-style; valid never drops without a transfer).
- count == 2: in_ready low until the current vector's last element transfers. in_ready rises in the cycle after that transfer.
- Wrap-around: wr_slot and rd_slot toggle indefinitely; the order of vectors is preserved.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

Optional Feature:
- Macro: SORT_STREAM_SERIALIZER_REVERSE_EN.
- Defined:
  - elements are emitted from index SIZE-1 down to 0;
  - idx starts at SIZE-1 and decrements;
  - out_last is asserted at idx == 0;
  - an ascending sort therefore streams out in descending order.
- Undefined: ascending index order as specified above.
- Ports are identical in both builds.

Test Plan (DEPTH=2, VALUE_BITS=8):
- Single vector: after reset, accept {3,7,9,12} (index 0 = 3) with out_ready held 1 -> out = 3,7,9,12 on four consecutive cycles, out_last only on 12, out_valid low afterwards, count back to 0.
- Back-to-back fill: accept vectors A = {1,2,3,4}, B = {5,6,7,8} and C = {9,10,11,12} on consecutive cycles with out_ready = 0 -> in_ready drops after B; C is held until the edge after A's element 4 transfers; the output stream is 1..12 with no gap and out_last on 4, 8 and 12.
- Backpressure: out_ready toggles 1,0,0,1,... during vector {10,20,30,40} -> out and out_last are stable while stalled; exactly four transfers occur in order.
- Simultaneous accept and release: count = 2, and in the cycle the last element of the first vector transfers, in_valid is high -> no accept that cycle (in_ready = 0); the accept occurs the next cycle; count never exceeds 2.
- Reset mid-vector: assert rst after two of the four elements have transferred -> the next cycle has out_valid = 0, out = 0, in_ready = 1; the next accepted vector streams from its element 0.
- REVERSE_EN build: accept {3,7,9,12} -> out = 12,9,7,3, with out_last on 3.
